// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the clock datapath BCD counters.
//   bcd_t        : one BCD digit (0..9 in a 4-bit field)
//   bcd2_t       : packed {tens, units} digit pair
//   BCD_MAX      : largest legal BCD digit
//   MOD_HOURS    : modulus for a 24-hour stage
//   MOD_MIN_SEC  : modulus for minute/second stages
//   to_bcd2()    : binary (0..99) -> two BCD digits, used at elaboration
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd2_t;

    localparam bcd_t BCD_MAX     = 4'd9;
    localparam int   MOD_HOURS   = 24;
    localparam int   MOD_MIN_SEC = 60;

    // Only called with constant arguments, so it folds away at elaboration.
    function automatic bcd2_t to_bcd2(input int value);
        bcd2_t r;
        r.tens  = bcd_t'((value / 10) % 10);
        r.units = bcd_t'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
// Combinational single-digit increment/decrement with a programmable wrap
// limit. Increment past limit_i wraps to 0; decrement below 0 wraps to
// limit_i. wrap_o flags either wrap so the next digit up can be stepped.
//   digit_i : current digit value
//   limit_i : largest value this digit may hold
//   inc_i   : increment request (wins if both requests are high)
//   dec_i   : decrement request
//   digit_o : next digit value
//   wrap_o  : carry (on inc) or borrow (on dec) out of this digit
// -----------------------------------------------------------------------------
module bcd_digit_step
    import clock_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic [3:0] limit_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       wrap_o
);

    always_comb begin
        digit_o = digit_i;
        wrap_o  = 1'b0;
        if (inc_i) begin
            if (digit_i >= limit_i) begin
                digit_o = '0;
                wrap_o  = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dec_i) begin
            if (digit_i == '0) begin
                digit_o = limit_i;
                wrap_o  = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD modulo-MOD up/down counter with parallel load and registered
// wrap pulses for chaining seconds -> minutes -> hours stages.
//
// Parameters:
//   Count modulus (MOD) : count range 0..MOD-1 (2..100; 100 gives 00..99)
//   INIT : reset value in binary (< MOD)
//
// Ports:
//   ck         : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   up / down  : step requests; both high = hold
//   load       : parallel load strobe (highest priority)
//   load_tens  : BCD tens digit to load
//   load_units : BCD units digit to load
//   tens/units : registered BCD value
//   carry      : one-cycle pulse coincident with up-wrap to 00
//   borrow     : one-cycle pulse coincident with down-wrap to MOD-1
//   load_err   : one-cycle pulse on a rejected load
//
// Build option:
//   BCD_MOD_COUNTER_LOAD_CHECK_EN - when defined, a rejected load pulses
//   load_err; otherwise rejected loads are silently ignored and load_err is 0.
// -----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MOD  = 24,
    parameter int INIT = 0
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       up,
    input  logic       down,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry,
    output logic       borrow,
    output logic       load_err
);

    localparam bcd2_t      TERM   = to_bcd2(MOD - 1);
    localparam bcd_t       MOD_T  = TERM.tens;
    localparam bcd_t       MOD_U  = TERM.units;
    localparam bcd2_t      INIT_B = to_bcd2(INIT);
    localparam logic [7:0] MOD_B  = 8'(MOD);

    bcd_t tens_q, tens_d;
    bcd_t units_q, units_d;
    logic carry_q, carry_d;
    logic borrow_q, borrow_d;

    bcd_t       u_next, t_next;
    logic       u_wrap, t_wrap;
    logic       step_up, step_dn;
    logic       at_max;
    logic [7:0] load_val;
    logic       load_ok;

    assign step_up = up & ~down;
    assign step_dn = down & ~up;
    assign at_max  = (tens_q == MOD_T) && (units_q == MOD_U);

    // Weighted value of the load digits; max 15*10+15 = 165 fits in 8 bits.
    assign load_val = (8'(load_tens) * 8'd10) + 8'(load_units);
    assign load_ok  = (load_tens <= BCD_MAX) && (load_units <= BCD_MAX) &&
                      (load_val < MOD_B);

    bcd_digit_step u_units_step (
        .digit_i (units_q),
        .limit_i (BCD_MAX),
        .inc_i   (step_up),
        .dec_i   (step_dn),
        .digit_o (u_next),
        .wrap_o  (u_wrap)
    );

    // Tens only moves when units wraps. Its down-wrap fires only from 00,
    // which is exactly the counter-level borrow condition.
    bcd_digit_step u_tens_step (
        .digit_i (tens_q),
        .limit_i (MOD_T),
        .inc_i   (step_up & u_wrap),
        .dec_i   (step_dn & u_wrap),
        .digit_o (t_next),
        .wrap_o  (t_wrap)
    );

    always_comb begin
        tens_d   = tens_q;
        units_d  = units_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            // A rejected load also swallows any up/down in the same cycle.
            if (load_ok) begin
                tens_d  = load_tens;
                units_d = load_units;
            end
        end else if (step_up) begin
            if (at_max) begin
                tens_d  = '0;
                units_d = '0;
                carry_d = 1'b1;
            end else begin
                tens_d  = t_next;
                units_d = u_next;
            end
        end else if (step_dn) begin
            tens_d   = t_next;
            units_d  = t_wrap ? MOD_U : u_next;
            borrow_d = t_wrap;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            tens_q   <= INIT_B.tens;
            units_q  <= INIT_B.units;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            tens_q   <= tens_d;
            units_q  <= units_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    logic load_err_q, load_err_d;

    assign load_err_d = load & ~load_ok;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

    assign tens   = tens_q;
    assign units  = units_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_mod_counter
// Directed bench driving five counter instances from one shared stimulus:
//   index 0: MOD=24  INIT=0
//   index 1: MOD=60  INIT=0
//   index 2: MOD=12  INIT=1
//   index 3: MOD=100 INIT=0
//   index 4: MOD=2   INIT=0
// -----------------------------------------------------------------------------
module tb_bcd_mod_counter;

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       ck = 1'b0;
    logic       rst_n = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lt = 4'd0;
    logic [3:0] lu = 4'd0;

    logic [3:0] tn [5];
    logic [3:0] un [5];
    logic       cy [5];
    logic       bw [5];
    logic       le [5];

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    bcd_mod_counter #(.MOD(24), .INIT(0)) u_c24 (
        .ck(ck), .rst_n(rst_n), .up(up), .down(down), .load(load),
        .load_tens(lt), .load_units(lu), .tens(tn[0]), .units(un[0]),
        .carry(cy[0]), .borrow(bw[0]), .load_err(le[0]));

    bcd_mod_counter #(.MOD(60), .INIT(0)) u_c60 (
        .ck(ck), .rst_n(rst_n), .up(up), .down(down), .load(load),
        .load_tens(lt), .load_units(lu), .tens(tn[1]), .units(un[1]),
        .carry(cy[1]), .borrow(bw[1]), .load_err(le[1]));

    bcd_mod_counter #(.MOD(12), .INIT(1)) u_c12 (
        .ck(ck), .rst_n(rst_n), .up(up), .down(down), .load(load),
        .load_tens(lt), .load_units(lu), .tens(tn[2]), .units(un[2]),
        .carry(cy[2]), .borrow(bw[2]), .load_err(le[2]));

    bcd_mod_counter #(.MOD(100), .INIT(0)) u_c100 (
        .ck(ck), .rst_n(rst_n), .up(up), .down(down), .load(load),
        .load_tens(lt), .load_units(lu), .tens(tn[3]), .units(un[3]),
        .carry(cy[3]), .borrow(bw[3]), .load_err(le[3]));

    bcd_mod_counter #(.MOD(2), .INIT(0)) u_c2 (
        .ck(ck), .rst_n(rst_n), .up(up), .down(down), .load(load),
        .load_tens(lt), .load_units(lu), .tens(tn[4]), .units(un[4]),
        .carry(cy[4]), .borrow(bw[4]), .load_err(le[4]));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int val(input int i);
        return int'({tn[i], un[i]});
    endfunction

    // Advance one edge and settle 1 ns past it before checking/driving.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        @(posedge ck);
        #1;
        up = 1'b0; down = 1'b0; load = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_c24_val", val(0), 'h00);
        check("rst_c12_val", val(2), 'h01);
        check("rst_c24_carry", int'(cy[0]), 0);
        check("rst_c24_borrow", int'(bw[0]), 0);
        check("rst_c24_err", int'(le[0]), 0);

        // Up held 24 cycles: MOD=24 chains 00..23,00; MOD=2 toggles
        up = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            check($sformatf("up24_val_%0d", i), val(0), bcd(i % 24));
            check($sformatf("up24_carry_%0d", i), int'(cy[0]), (i == 24) ? 1 : 0);
            check($sformatf("up2_val_%0d", i), val(4), i % 2);
            check($sformatf("up2_carry_%0d", i), int'(cy[4]), (i % 2 == 0) ? 1 : 0);
        end
        check("up_c60_val", val(1), 'h24);
        check("up_c12_val", val(2), 'h01);
        check("up_c100_val", val(3), 'h24);

        // Down wrap from 00
        do_reset();
        down = 1'b1;
        step();
        check("dn60_wrap_val", val(1), 'h59);
        check("dn60_wrap_borrow", int'(bw[1]), 1);
        check("dn24_wrap_val", val(0), 'h23);
        check("dn100_wrap_val", val(3), 'h99);
        step();
        check("dn60_next_val", val(1), 'h58);
        check("dn60_next_borrow", int'(bw[1]), 0);
        check("dn24_next_val", val(0), 'h22);
        down = 1'b0;
        step();
        check("dn60_hold_val", val(1), 'h58);

        // Legal load 17, then up and down together hold
        load = 1'b1; lt = 4'd1; lu = 4'd7;
        step();
        check("ld17_c24_val", val(0), 'h17);
        check("ld17_c24_err", int'(le[0]), 0);
        check("ld17_c2_err", int'(le[4]), ERR_EN);
        check("ld17_c2_val", val(4), 0);
        load = 1'b0; up = 1'b1; down = 1'b1;
        step();
        check("both_c24_val", val(0), 'h17);
        check("both_c24_carry", int'(cy[0]), 0);
        check("both_c24_borrow", int'(bw[0]), 0);

        // Load beats up
        down = 1'b0; load = 1'b1; lt = 4'd0; lu = 4'd5;
        step();
        check("ldup_c24_val", val(0), 'h05);

        // Illegal loads on MOD=24
        up = 1'b0; lt = 4'd2; lu = 4'd4;
        step();
        check("ill24_val", val(0), 'h05);
        check("ill24_err", int'(le[0]), ERR_EN);
        load = 1'b0;
        step();
        check("ill24_err_fall", int'(le[0]), 0);
        check("ill24_hold", val(0), 'h05);
        load = 1'b1; lt = 4'd0; lu = 4'hA; up = 1'b1;
        step();
        check("ill0A_val", val(0), 'h05);
        check("ill0A_err", int'(le[0]), ERR_EN);
        load = 1'b0; up = 1'b0;
        step();
        check("ill0A_err_fall", int'(le[0]), 0);

        // Async reset mid-count on MOD=12, INIT=1
        do_reset();
        up = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("c12_pre_rst", val(2), 'h08);
        up = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("c12_async_val", val(2), 'h01);
        check("c12_async_carry", int'(cy[2]), 0);
        check("c12_async_borrow", int'(bw[2]), 0);
        rst_n = 1'b1;

        // Wrap at 99 on the 100-count instance
        step();
        load = 1'b1; lt = 4'd9; lu = 4'd9;
        step();
        check("c100_ld99", val(3), 'h99);
        check("c100_ld99_err", int'(le[3]), 0);
        check("c24_ld99_err", int'(le[0]), ERR_EN);
        load = 1'b0; up = 1'b1;
        step();
        check("c100_wrap_val", val(3), 'h00);
        check("c100_wrap_carry", int'(cy[3]), 1);
        step();
        check("c100_next_val", val(3), 'h01);
        check("c100_next_carry", int'(cy[3]), 0);
        up = 1'b0; load = 1'b1; lt = 4'hA; lu = 4'd0;
        step();
        check("c100_illA0_val", val(3), 'h01);
        check("c100_illA0_err", int'(le[3]), ERR_EN);
        load = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Two-digit BCD modulo counter, the parametrised successor of the fixed 0–23 hour counter in the clock datapath. Modulus is set at elaboration, so one block serves hours (24 or 12), minutes and seconds (60). Adds down-count, parallel load, and registered wrap/borrow pulses so stages can be chained (seconds -> minutes -> hours). Sits between the tick/button logic and the 7-segment display digit registers.

Parameters:
MOD, 24, count range 0..MOD-1; legal 2..100 (100 gives 00–99).
INIT, 0, reset value in binary; must be < MOD; split to BCD at elaboration.

Ports:
ck  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
up  in  1  increment request, one step per cycle while high.
down  in  1  decrement request, one step per cycle while high.
load  in  1  parallel load strobe.
load_tens  in  4  BCD tens digit to load.
load_units  in  4  BCD units digit to load.
tens  out  4  registered BCD tens digit (display4 role).
units  out  4  registered BCD units digit (display3 role).
carry  out  1  one-cycle pulse on up-wrap MOD-1 -> 0.
borrow  out  1  one-cycle pulse on down-wrap 0 -> MOD-1.
load_err  out  1  one-cycle pulse on a rejected load (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): tens/units = BCD(INIT); carry, borrow, load_err = 0. Release takes effect at the next ck edge; there are no pending operations.
- All outputs are registered; an action sampled at edge N is visible after edge N (latency 1).
- Priority per edge: load > (up XOR down) > hold.
  - up and down both high: hold; no pulses.
- Up step:
  - units == 9: units = 0, tens + 1.
  - value == MOD-1: tens = units = 0 and carry = 1 for that cycle.
  - otherwise units + 1.
- Down step:
  - value == 0: set MOD-1 in BCD and borrow = 1 for that cycle.
  - units == 0: units = 9, tens - 1.
  - otherwise units - 1.
- carry/borrow are registered and coincide with the wrapped value appearing. They fall the next cycle unless another wrap occurs (e.g. MOD = 2 with up held).
- Load is legal when both digits ≤ 9 and tens*10 + units < MOD.
  - Legal load: digits copied; no carry/borrow.
  - Illegal load: counter holds; up/down in the same cycle are also ignored.
- MOD = 100: wrap at 99; the tens digit never exceeds 9.
- Invariant: tens*10 + units < MOD and both digits ≤ 9 at all times after reset.
- Comparisons use the 4-bit digit fields directly. The compile-time constants MOD_T = (MOD-1)/10 and MOD_U = (MOD-1)%10 avoid any runtime binary conversion.

Optional Feature:
- Macro: BCD_MOD_COUNTER_LOAD_CHECK_EN.
- Defined: an illegal load pulses load_err high for exactly one cycle, registered and coincident with the held value; the counter holds.
- Undefined: an illegal load is silently ignored; load_err is tied to 0.
- Legal-load and counting behaviour are identical in both builds.

Decomposition:
- Shared package clock_pkg holds:
  - typedef bcd_t (4-bit);
  - constants BCD_MAX = 9, MOD_HOURS = 24, MOD_MIN_SEC = 60;
  - function to_bcd2 (binary -> two BCD digits), used for INIT and MOD-1.
- One natural sub-module, bcd_digit_step: combinational single-digit inc/dec with wrap limit input and carry/borrow out. Instantiated twice (units limit 9, tens limit MOD_T).
- The parent handles the MOD-1 terminal compare and all registers.

Test Plan:
- Reset and chain: MOD=24, INIT=0, up held 24 cycles -> 00,01..09,10..23,00; carry high exactly in the cycle showing 00.
- Down wrap: MOD=60, value 00, pulse down -> 59 and borrow=1 one cycle; next down -> 58, borrow=0.
- Simultaneous and priority:
  - up=down=1 at 17 -> holds 17, no pulses;
  - load 05 with up=1 -> 05, not 06.
- Illegal load (MOD=24, macro defined):
  - load 2,4 -> holds previous value, load_err=1 one cycle;
  - load 0,A -> same;
  - macro undefined: load_err stays 0.
- Async reset mid-count: MOD=12, INIT=1, count to 08, assert rst_n between edges -> outputs 01 immediately with no clock; pulses 0.
- MOD=100 and MOD=2 edge cases:
  - 99 + up -> 00 with carry;
  - MOD=2 with up held -> 0,1,0,1 and carry on every return to 0.
